multdiv_controller: RTL
=======================

// Module: multdiv_controller
// PURPOSE
//  Execute-stage sequencer for the shared multi-cycle multiplier/divider.
//  Detects a decoded R-type mul/div in X and latches its operands and rd.
//  Pulses the unit's start strobe and stalls F/D/X until the unit reports ready.
//  Then returns the result, or the rstatus exception write, to the X/M latch.
// PARAMETERS
//  TIMEOUT_CYCLES  40  WAIT cycles allowed before forcing completion with timeout
//  MUL_EXC_CODE    1   rstatus value written on multiply overflow
//  DIV_EXC_CODE    2   rstatus value written on divide exception (div by zero)
//  TMO_EXC_CODE    3   rstatus value written on timeout
// PORTS
//  clock          in   1   system clock, rising edge
//  reset          in   1   synchronous, active-low (0 = reset)
//  valid_x        in   1   X-stage instruction valid (not a bubble)
//  opcode_x       in   5   X-stage opcode (instr[31:27])
//  alu_op_x       in   5   X-stage ALU op (instr[6:2])
//  rd_x           in   5   X-stage destination (instr[26:22])
//  operand_a      in   32  bypassed rs value
//  operand_b      in   32  bypassed rt value
//  flush          in   1   kill X-stage instruction (interrupt/redirect)
//  md_ctrl_mult   out  1   one-cycle start strobe, multiply
//  md_ctrl_div    out  1   one-cycle start strobe, divide
//  md_a, md_b     out  32  latched operands, stable from ISSUE until exit
//  md_result      in   32  unit result
//  md_exception   in   1   unit exception, valid with md_result_rdy
//  md_result_rdy  in   1   unit completion flag
//  stall          out  1   freeze PC, F/D and D/X latches
//  wb_valid       out  1   one-cycle: wb_rd/wb_data valid for X/M
//  wb_rd          out  5   destination register
//  wb_data        out  32  result or exception code
//  timeout_err    out  1   one-cycle pulse, concurrent with wb_valid on timeout
// BEHAVIOUR
//  - Start condition: valid_x & opcode_x==5'b00000 & alu_op_x in {5'b00110 mul, 5'b00111 div} & !flush & state==IDLE
//  - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE
//  - IDLE: on start, latch a, b, rd and kind (mul/div); stall=1 combinationally in the same cycle.
//  - ISSUE: exactly one of md_ctrl_mult/md_ctrl_div =1. Clear cycle counter. stall=1. Go to WAIT.
//  - WAIT: stall=1 and counter++.
//    - md_result_rdy=1: capture result and exception, go to DONE.
//    - Counter reaches TIMEOUT_CYCLES-1 without rdy: mark timeout, go to DONE.
//    - md_result_rdy is ignored in every state except WAIT; a rdy during ISSUE is ignored.
//  - DONE: stall=0 so the mul/div moves X->M next edge; wb_valid=1. Never restart from DONE.
//  - Write-back data rules, applied in DONE:
//    - Normal: wb_rd=latched rd, wb_data=md_result. rd=0 still pulses wb_valid; the regfile drops it.
//    - Exception: wb_rd=30, wb_data=MUL_EXC_CODE or DIV_EXC_CODE by kind.
//    - Timeout: wb_rd=30, wb_data=TMO_EXC_CODE, timeout_err=1.
//  - Latency: start detected in cycle t; strobe in t+1. If rdy is first seen in WAIT cycle t+1+k (k>=1), DONE is t+2+k. Stall cycles = k+2.
//  - Back-to-back: after DONE the state is IDLE as the next instruction enters X, so a second mul/div starts with zero bubble.
//  - Flush in ISSUE/WAIT: IDLE next edge, no wb_valid, stall=0 from that edge. The unit's later rdy is ignored.
//  - Flush in DONE: wb_valid forced 0.
//  - Flush and rdy in the same cycle: flush wins.
//  - Reset (reset==0 at edge) in any state: state=IDLE.
//    - All outputs 0: stall, strobes, wb_valid, timeout_err, wb_rd, wb_data, md_a, md_b.
//    - Counter 0; in-flight operation abandoned.
//  - Counter width: $clog2(TIMEOUT_CYCLES)+1. Saturates; never wraps.
// STRUCTURE
//  - Shared package cpu_pkg, constants only:
//    - OP_RTYPE=5'b00000, ALU_MUL=5'b00110, ALU_DIV=5'b00111
//    - REG_RSTATUS=5'd30
//    - FSM state encoding md_state_t
//  - One sub-module: md_cycle_counter (sync clear, enable, saturate, terminal-count flag).
//  - Exception codes stay parameters, not package constants.
// TESTING
//  1. mul, a=7, b=6, rd=5; rdy 16 cycles after strobe -> one md_ctrl_mult pulse, 18 stall cycles, wb_valid with rd=5, data=42.
//  2. div, a=9, b=0; exception with rdy -> wb_rd=30, wb_data=2; no md_ctrl_mult; timeout_err=0.
//  3. mul then div back-to-back in X -> second strobe 2 cycles after first wb_valid; both write-backs correct, no lost instruction.
//  4. flush in WAIT cycle 5, rdy later -> no wb_valid, stall low from next edge; a following mul starts cleanly.
//  5. rdy never asserted, TIMEOUT_CYCLES=40 -> DONE after 40 WAIT cycles; timeout_err=1, wb_rd=30, wb_data=3.
//  6. reset low mid-WAIT, then rdy -> all outputs 0, IDLE, rdy ignored. Also: rd=0 mul -> wb_valid=1, wb_rd=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU decode constants and the mul/div sequencer state encoding.
package cpu_pkg;

  localparam logic [4:0] OP_RTYPE    = 5'b00000;
  localparam logic [4:0] ALU_MUL     = 5'b00110;
  localparam logic [4:0] ALU_DIV     = 5'b00111;
  localparam logic [4:0] REG_RSTATUS = 5'd30;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_ISSUE = 2'd1,
    MD_WAIT  = 2'd2,
    MD_DONE  = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_cycle_counter.sv
// Saturating cycle counter with synchronous clear and a terminal-count flag.
module md_cycle_counter #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned TERMINAL = 39
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/multdiv_controller.sv
// Execute-stage sequencer for the shared multi-cycle multiplier/divider.
module multdiv_controller
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter logic [31:0] MUL_EXC_CODE   = 32'd1,
  parameter logic [31:0] DIV_EXC_CODE   = 32'd2,
  parameter logic [31:0] TMO_EXC_CODE   = 32'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_x,
  input  logic [4:0]  opcode_x,
  input  logic [4:0]  alu_op_x,
  input  logic [4:0]  rd_x,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_result_rdy,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  md_state_t   state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [4:0]  rd_q, rd_d;
  logic        div_q, div_d, exc_q, exc_d, tmo_q, tmo_d;
  logic        start, cnt_clear, cnt_en, cnt_tc;

  md_cycle_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  assign start = valid_x && (opcode_x == OP_RTYPE) &&
                 ((alu_op_x == ALU_MUL) || (alu_op_x == ALU_DIV)) &&
                 !flush && (state_q == MD_IDLE);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    rd_d         = rd_q;
    div_d        = div_q;
    result_d     = result_q;
    exc_d        = exc_q;
    tmo_d        = tmo_q;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    stall        = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    timeout_err  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          a_d     = operand_a;
          b_d     = operand_b;
          rd_d    = rd_x;
          div_d   = (alu_op_x == ALU_DIV);
          state_d = MD_ISSUE;
        end
      end
      MD_ISSUE: begin
        stall        = 1'b1;
        md_ctrl_mult = !div_q;
        md_ctrl_div  = div_q;
        cnt_clear    = 1'b1;
        state_d      = flush ? MD_IDLE : MD_WAIT;
      end
      MD_WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        // Flush outranks a same-cycle rdy; rdy outranks the timeout.
        if (flush) begin
          state_d = MD_IDLE;
        end else if (md_result_rdy) begin
          result_d = md_result;
          exc_d    = md_exception;
          tmo_d    = 1'b0;
          state_d  = MD_DONE;
        end else if (cnt_tc) begin
          exc_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        wb_valid    = !flush;
        timeout_err = tmo_q && !flush;
        if (tmo_q) begin
          wb_rd   = REG_RSTATUS;
          wb_data = TMO_EXC_CODE;
        end else if (exc_q) begin
          wb_rd   = REG_RSTATUS;
          wb_data = div_q ? DIV_EXC_CODE : MUL_EXC_CODE;
        end else begin
          wb_rd   = rd_q;
          wb_data = result_q;
        end
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= MD_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      div_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      div_q    <= div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      tmo_q    <= tmo_d;
    end
  end

  assign md_a = a_q;
  assign md_b = b_q;

endmodule
